wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter_pkg.sv | 18 +
 rtl/wb_rr_arb2.sv | 93 +++++++++
 rtl/wb_port_arbiter.sv | 110 +++++++++++
 tb/tb_wb_port_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
//   ID_*                 : requester IDs reported on grant_id
//   DEFAULT_WIDTH        : default writeback data width
//   DEFAULT_STARVE_LIMIT : default secondary starvation threshold
//   RD_W                 : register index width
package wb_port_arbiter_pkg;

  localparam int unsigned DEFAULT_WIDTH        = 64;
  localparam int unsigned DEFAULT_STARVE_LIMIT = 4;
  localparam int unsigned RD_W                 = 5;
  localparam int unsigned ID_W                 = 2;

  localparam logic [ID_W-1:0] ID_PIPE = 2'd0;
  localparam logic [ID_W-1:0] ID_MD   = 2'd1;
  localparam logic [ID_W-1:0] ID_LSU  = 2'd2;
  localparam logic [ID_W-1:0] ID_NONE = 2'd3;

endpackage

// File: rtl/wb_rr_arb2.sv
// Two-way round-robin between the mul/div and load-return requesters, with
// per-requester starvation counters.
//   clk, reset_n      : clock, async active-low reset
//   md_req, lsu_req   : requester valid with a nonzero destination
//   md_acc, lsu_acc   : requester was accepted this cycle (from the top)
//   md_sel_c          : md is the preferred secondary this cycle
//   lsu_sel_c         : lsu is the preferred secondary this cycle
//   sec_urgent_c      : the preferred secondary is saturated and outranks pipe
module wb_rr_arb2
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic md_req,
  input  logic lsu_req,
  input  logic md_acc,
  input  logic lsu_acc,
  output logic md_sel_c,
  output logic lsu_sel_c,
  output logic sec_urgent_c
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  // ptr == 0 favours md, ptr == 1 favours lsu
  logic             ptr_q, ptr_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] lsu_cnt_q, lsu_cnt_d;
  logic             md_sat, lsu_sat;

  assign md_sat  = (md_cnt_q == CNT_MAX);
  assign lsu_sat = (lsu_cnt_q == CNT_MAX);

  // Secondary selection: a lone saturated requester beats the pointer,
  // otherwise the pointer decides when both request.
  always_comb begin
    md_sel_c     = 1'b0;
    lsu_sel_c    = 1'b0;
    sec_urgent_c = 1'b0;
    if (md_req && lsu_req) begin
      if (md_sat && !lsu_sat) begin
        md_sel_c = 1'b1;
      end else if (lsu_sat && !md_sat) begin
        lsu_sel_c = 1'b1;
      end else if (!ptr_q) begin
        md_sel_c = 1'b1;
      end else begin
        lsu_sel_c = 1'b1;
      end
    end else if (md_req) begin
      md_sel_c = 1'b1;
    end else if (lsu_req) begin
      lsu_sel_c = 1'b1;
    end
    sec_urgent_c = (md_sel_c && md_sat) || (lsu_sel_c && lsu_sat);
  end

  // Next-state for pointer and counters.
  always_comb begin
    ptr_d     = ptr_q;
    md_cnt_d  = md_cnt_q;
    lsu_cnt_d = lsu_cnt_q;
    if (md_acc || lsu_acc) begin
      ptr_d = ~ptr_q;
    end
    if (!md_req || md_acc) begin
      md_cnt_d = '0;
    end else if (!md_sat) begin
      md_cnt_d = md_cnt_q + CNT_W'(1);
    end
    if (!lsu_req || lsu_acc) begin
      lsu_cnt_d = '0;
    end else if (!lsu_sat) begin
      lsu_cnt_d = lsu_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q     <= 1'b0;
      md_cnt_q  <= '0;
      lsu_cnt_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      md_cnt_q  <= md_cnt_d;
      lsu_cnt_q <= lsu_cnt_d;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file writeback arbiter: pipeline has priority over mul/div and
// load-return unless a secondary is starved; one write per cycle, latency 1.
//   clk, reset_n                        : clock, async active-low reset
//   pipe_valid/ready, pipe_rd/data      : requester 0
//   md_valid/ready, md_rd/data          : requester 1
//   lsu_valid/ready, lsu_rd/data        : requester 2
//   reg_write, rd, writedata, grant_id  : registered register-file write
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH        = DEFAULT_WIDTH,
  parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pipe_valid,
  output logic              pipe_ready,
  input  logic [RD_W-1:0]   pipe_rd,
  input  logic [WIDTH-1:0]  pipe_data,
  input  logic              md_valid,
  output logic              md_ready,
  input  logic [RD_W-1:0]   md_rd,
  input  logic [WIDTH-1:0]  md_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [RD_W-1:0]   lsu_rd,
  input  logic [WIDTH-1:0]  lsu_data,
  output logic              reg_write,
  output logic [RD_W-1:0]   rd,
  output logic [WIDTH-1:0]  writedata,
  output logic [ID_W-1:0]   grant_id
);

  logic pipe_req, md_req, lsu_req;
  logic pipe_acc, md_acc, lsu_acc;
  logic md_sel_c, lsu_sel_c, sec_urgent_c;

  logic             acc_any;
  logic [ID_W-1:0]  acc_id;
  logic [RD_W-1:0]  acc_rd;
  logic [WIDTH-1:0] acc_data;

  // rd == 0 requests never compete; they are swallowed on sight.
  assign pipe_req = pipe_valid && (pipe_rd != '0);
  assign md_req   = md_valid   && (md_rd   != '0);
  assign lsu_req  = lsu_valid  && (lsu_rd  != '0);

  wb_rr_arb2 #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_rr (
    .clk          (clk),
    .reset_n      (reset_n),
    .md_req       (md_req),
    .lsu_req      (lsu_req),
    .md_acc       (md_acc),
    .lsu_acc      (lsu_acc),
    .md_sel_c     (md_sel_c),
    .lsu_sel_c    (lsu_sel_c),
    .sec_urgent_c (sec_urgent_c)
  );

  // Pipe wins unless the preferred secondary is saturated.
  assign pipe_acc = reset_n && pipe_req && !sec_urgent_c;
  assign md_acc   = reset_n && md_sel_c  && !pipe_acc;
  assign lsu_acc  = reset_n && lsu_sel_c && !pipe_acc;

  assign pipe_ready = reset_n && pipe_valid && ((pipe_rd == '0) || pipe_acc);
  assign md_ready   = reset_n && md_valid   && ((md_rd   == '0) || md_acc);
  assign lsu_ready  = reset_n && lsu_valid  && ((lsu_rd  == '0) || lsu_acc);

  // Mux the accepted request into the write register.
  always_comb begin
    acc_any  = 1'b0;
    acc_id   = ID_NONE;
    acc_rd   = pipe_rd;
    acc_data = pipe_data;
    if (pipe_acc) begin
      acc_any = 1'b1;
      acc_id  = ID_PIPE;
    end else if (md_acc) begin
      acc_any  = 1'b1;
      acc_id   = ID_MD;
      acc_rd   = md_rd;
      acc_data = md_data;
    end else if (lsu_acc) begin
      acc_any  = 1'b1;
      acc_id   = ID_LSU;
      acc_rd   = lsu_rd;
      acc_data = lsu_data;
    end
  end

  // Write register; rd/writedata hold when nothing is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_write <= 1'b0;
      rd        <= '0;
      writedata <= '0;
      grant_id  <= ID_NONE;
    end else begin
      reg_write <= acc_any;
      grant_id  <= acc_id;
      if (acc_any) begin
        rd        <= acc_rd;
        writedata <= acc_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter.
module tb_wb_port_arbiter;

  logic        clk;
  logic        reset_n;
  logic        pipe_valid, pipe_ready;
  logic [4:0]  pipe_rd;
  logic [63:0] pipe_data;
  logic        md_valid, md_ready;
  logic [4:0]  md_rd;
  logic [63:0] md_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [63:0] lsu_data;
  logic        reg_write;
  logic [4:0]  rd;
  logic [63:0] writedata;
  logic [1:0]  grant_id;

  int tests_run;
  int tests_failed;

  wb_port_arbiter #(.WIDTH(64), .STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pipe_valid (pipe_valid),
    .pipe_ready (pipe_ready),
    .pipe_rd    (pipe_rd),
    .pipe_data  (pipe_data),
    .md_valid   (md_valid),
    .md_ready   (md_ready),
    .md_rd      (md_rd),
    .md_data    (md_data),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .reg_write  (reg_write),
    .rd         (rd),
    .writedata  (writedata),
    .grant_id   (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
    md_valid   = 1'b0; md_rd   = '0; md_data   = '0;
    lsu_valid  = 1'b0; lsu_rd  = '0; lsu_data  = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    pipe_valid = 1'b1; pipe_rd = 5'd1;
    md_valid = 1'b1; md_rd = 5'd2;
    lsu_valid = 1'b1; lsu_rd = 5'd0;
    #1;
    step();
    tests_run++; if (reg_write !== 1'b0) begin tests_failed++; $display("FAIL reset_reg_write: got %b want 0", reg_write); end
    tests_run++; if (rd !== 5'd0) begin tests_failed++; $display("FAIL reset_rd: got %0d want 0", rd); end
    tests_run++; if (writedata !== 64'd0) begin tests_failed++; $display("FAIL reset_writedata: got %h want 0", writedata); end
    tests_run++; if (grant_id !== 2'd3) begin tests_failed++; $display("FAIL reset_grant_id: got %0d want 3", grant_id); end
    tests_run++; if ({pipe_ready, md_ready, lsu_ready} !== 3'b000) begin tests_failed++; $display("FAIL reset_ready: got %b want 000", {pipe_ready, md_ready, lsu_ready}); end
    idle();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_pipe_priority();
    idle();
    pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 64'hAA;
    md_valid = 1'b1; md_rd = 5'd6; md_data = 64'hBB;
    #1;
    tests_run++; if (pipe_ready !== 1'b1) begin tests_failed++; $display("FAIL prio_pipe_ready: got %b want 1", pipe_ready); end
    tests_run++; if (md_ready !== 1'b0) begin tests_failed++; $display("FAIL prio_md_ready: got %b want 0", md_ready); end
    step();
    tests_run++; if ({reg_write, rd, writedata, grant_id} !== {1'b1, 5'd5, 64'hAA, 2'd0}) begin tests_failed++; $display("FAIL prio_write: got we=%b rd=%0d wd=%h id=%0d want we=1 rd=5 wd=aa id=0", reg_write, rd, writedata, grant_id); end
    idle();
    step();
    tests_run++; if ({reg_write, rd, writedata, grant_id} !== {1'b0, 5'd5, 64'hAA, 2'd3}) begin tests_failed++; $display("FAIL idle_hold: got we=%b rd=%0d wd=%h id=%0d want we=0 rd=5 wd=aa id=3", reg_write, rd, writedata, grant_id); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id [3];
    logic [4:0] exp_rd [3];
    exp_id[0] = 2'd1; exp_id[1] = 2'd2; exp_id[2] = 2'd1;
    exp_rd[0] = 5'd7; exp_rd[1] = 5'd8; exp_rd[2] = 5'd7;
    idle();
    md_valid = 1'b1; md_rd = 5'd7; md_data = 64'h77;
    lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 64'h88;
    #1;
    tests_run++; if ({md_ready, lsu_ready} !== 2'b10) begin tests_failed++; $display("FAIL rr_first_ready: got %b want 10", {md_ready, lsu_ready}); end
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++; if ({reg_write, grant_id, rd} !== {1'b1, exp_id[i], exp_rd[i]}) begin tests_failed++; $display("FAIL rr_grant_%0d: got we=%b id=%0d rd=%0d want we=1 id=%0d rd=%0d", i, reg_write, grant_id, rd, exp_id[i], exp_rd[i]); end
    end
    idle();
    step();
  endtask

  task automatic test_starvation();
    idle();
    pipe_valid = 1'b1; pipe_rd = 5'd1;
    md_valid = 1'b1; md_rd = 5'd9; md_data = 64'h99;
    for (int i = 0; i < 4; i++) begin
      pipe_data = 64'(i + 16);
      #1;
      tests_run++; if ({pipe_ready, md_ready} !== 2'b10) begin tests_failed++; $display("FAIL starve_loss_%0d: got pipe/md ready %b want 10", i, {pipe_ready, md_ready}); end
      step();
      tests_run++; if ({grant_id, writedata} !== {2'd0, 64'(i + 16)}) begin tests_failed++; $display("FAIL starve_pipe_write_%0d: got id=%0d wd=%h want id=0 wd=%h", i, grant_id, writedata, 64'(i + 16)); end
    end
    #1;
    tests_run++; if ({pipe_ready, md_ready} !== 2'b01) begin tests_failed++; $display("FAIL starve_win_ready: got pipe/md ready %b want 01", {pipe_ready, md_ready}); end
    step();
    tests_run++; if ({reg_write, grant_id, rd, writedata} !== {1'b1, 2'd1, 5'd9, 64'h99}) begin tests_failed++; $display("FAIL starve_md_write: got we=%b id=%0d rd=%0d wd=%h want we=1 id=1 rd=9 wd=99", reg_write, grant_id, rd, writedata); end
    md_valid = 1'b0; md_rd = '0;
    pipe_data = 64'h20;
    step();
    tests_run++; if ({grant_id, writedata} !== {2'd0, 64'h20}) begin tests_failed++; $display("FAIL starve_pipe_resume: got id=%0d wd=%h want id=0 wd=20", grant_id, writedata); end
    idle();
    step();
  endtask

  task automatic test_rd_zero();
    idle();
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 64'h55;
    pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 64'h33;
    #1;
    tests_run++; if ({pipe_ready, lsu_ready} !== 2'b11) begin tests_failed++; $display("FAIL rd0_ready: got pipe/lsu ready %b want 11", {pipe_ready, lsu_ready}); end
    step();
    tests_run++; if ({reg_write, grant_id, rd, writedata} !== {1'b1, 2'd0, 5'd3, 64'h33}) begin tests_failed++; $display("FAIL rd0_pipe_write: got we=%b id=%0d rd=%0d wd=%h want we=1 id=0 rd=3 wd=33", reg_write, grant_id, rd, writedata); end
    pipe_valid = 1'b0; pipe_rd = '0;
    #1;
    tests_run++; if (lsu_ready !== 1'b1) begin tests_failed++; $display("FAIL rd0_alone_ready: got %b want 1", lsu_ready); end
    step();
    tests_run++; if ({reg_write, grant_id, rd} !== {1'b0, 2'd3, 5'd3}) begin tests_failed++; $display("FAIL rd0_no_write: got we=%b id=%0d rd=%0d want we=0 id=3 rd=3", reg_write, grant_id, rd); end
    idle();
  endtask

  task automatic test_back_to_back();
    idle();
    pipe_valid = 1'b1; pipe_rd = 5'd4; pipe_data = 64'h1;
    step();
    tests_run++; if ({rd, writedata} !== {5'd4, 64'h1}) begin tests_failed++; $display("FAIL b2b_first: got rd=%0d wd=%h want rd=4 wd=1", rd, writedata); end
    pipe_data = 64'h2;
    step();
    tests_run++; if ({reg_write, rd, writedata} !== {1'b1, 5'd4, 64'h2}) begin tests_failed++; $display("FAIL b2b_second: got we=%b rd=%0d wd=%h want we=1 rd=4 wd=2", reg_write, rd, writedata); end
    idle();
    step();
  endtask

  task automatic test_reset_mid();
    idle();
    md_valid = 1'b1; md_rd = 5'd10; md_data = 64'hCC;
    #1;
    tests_run++; if (md_ready !== 1'b1) begin tests_failed++; $display("FAIL rmid_md_ready: got %b want 1", md_ready); end
    step();
    tests_run++; if ({reg_write, grant_id} !== {1'b1, 2'd1}) begin tests_failed++; $display("FAIL rmid_write: got we=%b id=%0d want we=1 id=1", reg_write, grant_id); end
    md_data = 64'hCD;
    reset_n = 1'b0;
    #1;
    tests_run++; if ({reg_write, rd, writedata, grant_id} !== {1'b0, 5'd0, 64'd0, 2'd3}) begin tests_failed++; $display("FAIL rmid_async_clear: got we=%b rd=%0d wd=%h id=%0d want we=0 rd=0 wd=0 id=3", reg_write, rd, writedata, grant_id); end
    tests_run++; if (md_ready !== 1'b0) begin tests_failed++; $display("FAIL rmid_ready_in_reset: got %b want 0", md_ready); end
    step();
    idle();
    reset_n = 1'b1;
    #1;
    tests_run++; if ({reg_write, grant_id} !== {1'b0, 2'd3}) begin tests_failed++; $display("FAIL rmid_after_release: got we=%b id=%0d want we=0 id=3", reg_write, grant_id); end
    md_valid = 1'b1; md_rd = 5'd7; md_data = 64'h77;
    lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 64'h88;
    #1;
    tests_run++; if ({md_ready, lsu_ready} !== 2'b10) begin tests_failed++; $display("FAIL rmid_ptr_md: got md/lsu ready %b want 10", {md_ready, lsu_ready}); end
    step();
    tests_run++; if ({reg_write, grant_id, rd} !== {1'b1, 2'd1, 5'd7}) begin tests_failed++; $display("FAIL rmid_resume: got we=%b id=%0d rd=%0d want we=1 id=1 rd=7", reg_write, grant_id, rd); end
    idle();
    step();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_pipe_priority();
    test_round_robin();
    test_starvation();
    test_rd_zero();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units");
    $fatal(1);
  end

endmodule
